// File: rtl/m_watch_alarm_if.sv
// Key inputs and display/LED outputs of the 24-hour watch with alarm.
interface m_watch_alarm_if;
  // key_first_1/key_first_2/key_long_1 are one-cycle pulses and key_long_2 is a level.
  // There is no backpressure: the watch acts on a pulse in the cycle that samples it.
  logic       key_first_1;
  logic       key_first_2;
  logic       key_long_1;
  logic       key_long_2;
  logic       led_point;
  logic       led_setting;
  logic       led_alarm;
  logic       alarm_out;
  logic [1:0] Hex_bit;
  logic [3:0] Hex_0;
  logic [3:0] Hex_1;
  logic [3:0] Hex_2;
  logic [3:0] Hex_3;
  logic [1:0] state_dbg;

  modport master (
    output key_first_1, key_first_2, key_long_1, key_long_2,
    input  led_point, led_setting, led_alarm, alarm_out,
    input  Hex_bit, Hex_0, Hex_1, Hex_2, Hex_3, state_dbg
  );

  modport slave (
    input  key_first_1, key_first_2, key_long_1, key_long_2,
    output led_point, led_setting, led_alarm, alarm_out,
    output Hex_bit, Hex_0, Hex_1, Hex_2, Hex_3, state_dbg
  );
endinterface

// File: rtl/m_watch_alarm.sv
// 24-hour BCD watch with edit copy, alarm setting, timed ring and silence.
// All outputs are registered; display and LEDs lag the internal state by one cycle.
module m_watch_alarm #(
  parameter int IN_CLK_HZ = 50_000_000,
  parameter int POINT_CS  = 25,
  parameter int ALARM_SEC = 30
) (
  input  logic           clk,
  input  logic           rst_n,
  m_watch_alarm_if.slave io
);
  localparam int TICK_DIV = IN_CLK_HZ / 100;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_TIME      = 2'd0,
    S_SEC       = 2'd1,
    S_SET_TIME  = 2'd2,
    S_SET_ALARM = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cs_q, cs_d, ss_q, ss_d, mm_q, mm_d, hh_q, hh_d;
  logic [7:0]    e_mm_q, e_mm_d, e_hh_q, e_hh_d;
  logic [7:0]    a_mm_q, a_mm_d, a_hh_q, a_hh_d;
  logic [7:0]    ring_q, ring_d;
  logic          alarm_en_q, alarm_en_d;
  logic          alarm_out_q, alarm_out_d;
  logic [1:0]    hex_bit_q, hex_bit_d;
  logic [1:0]    hex_bit_o_q, hex_bit_o_d;
  logic          led_point_q, led_point_d;
  logic          led_setting_q, led_setting_d;
  logic          led_alarm_q, led_alarm_d;
  logic [15:0]   disp_q, disp_d;

  logic          tick, tick_eff, silence, commit_time;
  logic          sec_carry, min_carry;
  logic [6:0]    cs_bin;

  // Next value of a two-digit BCD counter whose final value is 'last'.
  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] last);
    logic [7:0] r;
    if (v == last)            r = 8'h00;
    else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
    else                      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  always_comb begin
    tick        = (presc_q == PW'(TICK_DIV - 1));
    silence     = alarm_out_q & (io.key_first_1 | io.key_first_2 | io.key_long_1);
    commit_time = !silence && (state_q == S_SET_TIME) && io.key_long_1;
    // A time commit restarts the second, so a coincident tick is dropped.
    tick_eff    = tick && !commit_time;
    sec_carry   = 1'b0;
    min_carry   = 1'b0;

    presc_d = tick ? '0 : presc_q + 1'b1;
    cs_d    = cs_q;
    ss_d    = ss_q;
    mm_d    = mm_q;
    hh_d    = hh_q;
    if (tick_eff) begin
      cs_d = bcd_next(cs_q, 8'h99);
      if (cs_q == 8'h99) begin
        sec_carry = 1'b1;
        ss_d      = bcd_next(ss_q, 8'h59);
        if (ss_q == 8'h59) begin
          min_carry = 1'b1;
          mm_d      = bcd_next(mm_q, 8'h59);
          if (mm_q == 8'h59) hh_d = bcd_next(hh_q, 8'h23);
        end
      end
    end
    if (commit_time) begin
      presc_d = '0;
      cs_d    = 8'h00;
      ss_d    = 8'h00;
      mm_d    = e_mm_q;
      hh_d    = e_hh_q;
    end

    state_d    = state_q;
    hex_bit_d  = hex_bit_q;
    e_mm_d     = e_mm_q;
    e_hh_d     = e_hh_q;
    a_mm_d     = a_mm_q;
    a_hh_d     = a_hh_q;
    alarm_en_d = alarm_en_q;
    if (!silence) begin
      case (state_q)
        S_TIME: begin
          if (io.key_first_1) begin
            state_d   = S_SET_TIME;
            e_mm_d    = mm_q;
            e_hh_d    = hh_q;
            hex_bit_d = 2'd0;
          end else if (io.key_long_1) begin
            state_d   = S_SET_ALARM;
            e_mm_d    = a_mm_q;
            e_hh_d    = a_hh_q;
            hex_bit_d = 2'd0;
          end else if (io.key_long_2) begin
            state_d = S_SEC;
          end else if (io.key_first_2) begin
            alarm_en_d = ~alarm_en_q;
          end
        end
        S_SEC: begin
          if (!io.key_long_2) state_d = S_TIME;
        end
        default: begin
          if (io.key_long_1) begin
            state_d = S_TIME;
            if (state_q == S_SET_ALARM) begin
              a_mm_d = e_mm_q;
              a_hh_d = e_hh_q;
            end
          end else if (io.key_first_1) begin
            hex_bit_d = hex_bit_q + 2'd1;
          end else if (io.key_first_2) begin
            case (hex_bit_q)
              2'd0: e_mm_d[3:0] = (e_mm_q[3:0] >= 4'd9) ? 4'd0 : e_mm_q[3:0] + 4'd1;
              2'd1: e_mm_d[7:4] = (e_mm_q[7:4] >= 4'd5) ? 4'd0 : e_mm_q[7:4] + 4'd1;
              2'd2: begin
                if (e_hh_q[7:4] == 4'd2)
                  e_hh_d[3:0] = (e_hh_q[3:0] >= 4'd3) ? 4'd0 : e_hh_q[3:0] + 4'd1;
                else
                  e_hh_d[3:0] = (e_hh_q[3:0] >= 4'd9) ? 4'd0 : e_hh_q[3:0] + 4'd1;
              end
              default: begin
                e_hh_d[7:4] = (e_hh_q[7:4] >= 4'd2) ? 4'd0 : e_hh_q[7:4] + 4'd1;
                if (e_hh_d[7:4] == 4'd2 && e_hh_q[3:0] > 4'd3) e_hh_d[3:0] = 4'd0;
              end
            endcase
          end
        end
      endcase
    end

    ring_d      = ring_q;
    alarm_out_d = alarm_out_q;
    if (alarm_out_q && sec_carry) begin
      ring_d = ring_q - 8'd1;
      if (ring_q == 8'd1) alarm_out_d = 1'b0;
    end
    if (silence) alarm_out_d = 1'b0;
    // Compare against the alarm registers as they were before this edge.
    if (min_carry && alarm_en_q && !silence && mm_d == a_mm_q && hh_d == a_hh_q) begin
      alarm_out_d = 1'b1;
      ring_d      = 8'(ALARM_SEC);
    end
    if (!alarm_en_d) alarm_out_d = 1'b0;

    cs_bin        = 7'(cs_q[7:4]) * 7'd10 + 7'(cs_q[3:0]);
    led_point_d   = (cs_bin < 7'(POINT_CS));
    led_setting_d = (state_q == S_SET_TIME) || (state_q == S_SET_ALARM);
    led_alarm_d   = alarm_en_q;
    hex_bit_o_d   = hex_bit_q;
    case (state_q)
      S_TIME:  disp_d = {hh_q, mm_q};
      S_SEC:   disp_d = {ss_q, cs_q};
      default: disp_d = {e_hh_q, e_mm_q};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_TIME;
      presc_q       <= '0;
      cs_q          <= 8'h00;
      ss_q          <= 8'h00;
      mm_q          <= 8'h00;
      hh_q          <= 8'h00;
      e_mm_q        <= 8'h00;
      e_hh_q        <= 8'h00;
      a_mm_q        <= 8'h00;
      a_hh_q        <= 8'h00;
      ring_q        <= 8'h00;
      alarm_en_q    <= 1'b0;
      alarm_out_q   <= 1'b0;
      hex_bit_q     <= 2'd0;
      hex_bit_o_q   <= 2'd0;
      led_point_q   <= 1'b0;
      led_setting_q <= 1'b0;
      led_alarm_q   <= 1'b0;
      disp_q        <= 16'h0000;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      cs_q          <= cs_d;
      ss_q          <= ss_d;
      mm_q          <= mm_d;
      hh_q          <= hh_d;
      e_mm_q        <= e_mm_d;
      e_hh_q        <= e_hh_d;
      a_mm_q        <= a_mm_d;
      a_hh_q        <= a_hh_d;
      ring_q        <= ring_d;
      alarm_en_q    <= alarm_en_d;
      alarm_out_q   <= alarm_out_d;
      hex_bit_q     <= hex_bit_d;
      hex_bit_o_q   <= hex_bit_o_d;
      led_point_q   <= led_point_d;
      led_setting_q <= led_setting_d;
      led_alarm_q   <= led_alarm_d;
      disp_q        <= disp_d;
    end
  end

  assign io.led_point   = led_point_q;
  assign io.led_setting = led_setting_q;
  assign io.led_alarm   = led_alarm_q;
  assign io.alarm_out   = alarm_out_q;
  assign io.Hex_bit     = hex_bit_o_q;
  assign io.Hex_0       = disp_q[3:0];
  assign io.Hex_1       = disp_q[7:4];
  assign io.Hex_2       = disp_q[11:8];
  assign io.Hex_3       = disp_q[15:12];
  assign io.state_dbg   = state_q;
endmodule

// File: tb/tb_m_watch_alarm.sv
// Directed bench for m_watch_alarm at IN_CLK_HZ=500 (5 cycles per centisecond tick), ALARM_SEC=2.
module tb_m_watch_alarm;
  localparam int K_F1 = 0;
  localparam int K_F2 = 1;
  localparam int K_L1 = 2;

  logic        clk;
  logic        rst_n;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  int          t_com;
  int          r0;
  int          c2;
  logic [15:0] disp;
  logic [31:0] exp_q[$];
  logic [3:0]  u_tab[4];

  m_watch_alarm_if io ();

  m_watch_alarm #(.IN_CLK_HZ(500), .POINT_CS(25), .ALARM_SEC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  assign disp = {io.Hex_3, io.Hex_2, io.Hex_1, io.Hex_0};

  // clock / reset
  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    cyc   = 0;
  end
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sec_view(input int ticks);
    int s;
    int c;
    s = ticks / 100;
    c = ticks % 100;
    return {4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  // drivers
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic press(input int k);
    case (k)
      K_F1:    io.key_first_1 = 1'b1;
      K_F2:    io.key_first_2 = 1'b1;
      default: io.key_long_1  = 1'b1;
    endcase
    step(1);
    io.key_first_1 = 1'b0;
    io.key_first_2 = 1'b0;
    io.key_long_1  = 1'b0;
  endtask

  task automatic press_n(input int k, input int n);
    for (int i = 0; i < n; i++) press(k);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    io.key_first_1 = 1'b0;
    io.key_first_2 = 1'b0;
    io.key_long_1  = 1'b0;
    io.key_long_2  = 1'b0;
    u_tab = '{4'd1, 4'd2, 4'd3, 4'd0};

    // reset with keys toggling
    for (int i = 0; i < 3; i++) begin
      io.key_first_1 = i[0];
      io.key_first_2 = ~i[0];
      io.key_long_1  = i[0];
      io.key_long_2  = 1'b1;
      step(1);
    end
    check_eq("rst_disp", disp, 16'h0000);
    check_eq("rst_leds", {io.led_point, io.led_setting, io.led_alarm, io.alarm_out}, 4'b0000);
    check_eq("rst_hex_bit", io.Hex_bit, 2'd0);
    check_eq("rst_state", io.state_dbg, 2'd0);

    io.key_first_1 = 1'b0;
    io.key_first_2 = 1'b0;
    io.key_long_1  = 1'b0;
    io.key_long_2  = 1'b0;
    rst_n = 1'b1;
    r0 = cyc;
    step(1);
    check_eq("point_after_rst", io.led_point, 1'b1);
    check_eq("disp_after_rst", disp, 16'h0000);

    // tick period seen through SEC view
    io.key_long_2 = 1'b1;
    exp_q.push_back(32'h0000);
    exp_q.push_back(32'h0001);
    exp_q.push_back(32'h0001);
    exp_q.push_back(32'h0002);
    step_to(r0 + 5);
    check_eq("tick_r5", disp, exp_q.pop_front());
    step_to(r0 + 6);
    check_eq("tick_r6", disp, exp_q.pop_front());
    step_to(r0 + 10);
    check_eq("tick_r10", disp, exp_q.pop_front());
    step_to(r0 + 11);
    check_eq("tick_r11", disp, exp_q.pop_front());
    io.key_long_2 = 1'b0;
    step(1);
    check_eq("sec_exit_state", io.state_dbg, 2'd0);

    // SEC mode from 00:00:00.00 for one second
    press(K_F1);
    press(K_L1);
    t_com = cyc;
    check_eq("led_setting", io.led_setting, 1'b1);
    io.key_long_2 = 1'b1;
    step_to(t_com + 125);
    check_eq("point_cs24", io.led_point, 1'b1);
    step_to(t_com + 126);
    check_eq("point_cs25", io.led_point, 1'b0);
    step_to(t_com + 501);
    check_eq("sec_1s", disp, 16'h0100);
    io.key_long_2 = 1'b0;
    step(1);
    check_eq("sec_release_state", io.state_dbg, 2'd0);
    step(1);
    check_eq("sec_release_disp", disp, 16'h0000);

    // edit rules in SET_ALARM
    press(K_L1);
    press_n(K_F1, 3);
    press(K_F2);
    press_n(K_F1, 3);
    press_n(K_F2, 7);
    step(1);
    check_eq("edit_17", disp, 16'h1700);
    check_eq("edit_hex_bit", io.Hex_bit, 2'd2);
    press(K_F1);
    press(K_F2);
    step(1);
    check_eq("edit_tens2_force", disp, 16'h2000);
    press_n(K_F1, 3);
    for (int i = 0; i < 4; i++) begin
      press(K_F2);
      step(1);
      check_eq("edit_hr_units", io.Hex_2, u_tab[i]);
    end
    press_n(K_F1, 3);
    for (int i = 0; i < 6; i++) begin
      press(K_F2);
      step(1);
      check_eq("edit_min_tens", io.Hex_1, 4'((i + 1) % 6));
    end
    press(K_L1);
    io.key_long_2 = 1'b1;
    step(2);
    check_eq("time_ran_in_edit", disp, sec_view((cyc - 1 - t_com) / 5));
    io.key_long_2 = 1'b0;
    step(2);

    // alarm 20:00 -> 00:00, enable
    press(K_L1);
    step(1);
    check_eq("alarm_reload", disp, 16'h2000);
    press_n(K_F1, 3);
    press(K_F2);
    press(K_L1);
    press(K_F2);
    step(1);
    check_eq("led_alarm_on", io.led_alarm, 1'b1);

    // set 23:59 and commit exactly on a tick edge
    press(K_F1);
    press_n(K_F2, 9);
    press(K_F1);
    press_n(K_F2, 5);
    press(K_F1);
    press_n(K_F2, 3);
    press(K_F1);
    press_n(K_F2, 2);
    step(1);
    check_eq("edit_2359", disp, 16'h2359);
    while ((cyc + 1 - t_com) % 5 != 0) step(1);
    press(K_L1);
    c2 = cyc;
    io.key_long_2 = 1'b1;
    step_to(c2 + 5);
    check_eq("commit_tick_cs0", disp, 16'h0000);
    step_to(c2 + 6);
    check_eq("commit_presc_restart", disp, 16'h0001);
    io.key_long_2 = 1'b0;
    step(2);
    check_eq("commit_hhmm", disp, 16'h2359);

    // midnight rollover rings the 00:00 alarm
    step_to(c2 + 29999);
    check_eq("pre_midnight_disp", disp, 16'h2359);
    check_eq("pre_midnight_alarm", io.alarm_out, 1'b0);
    step_to(c2 + 30000);
    check_eq("midnight_alarm_on", io.alarm_out, 1'b1);
    step_to(c2 + 30001);
    check_eq("midnight_disp", disp, 16'h0000);

    // silence after 0.5 s
    step_to(c2 + 30249);
    press(K_F2);
    check_eq("silence_alarm", io.alarm_out, 1'b0);
    step(1);
    check_eq("silence_en_kept", io.led_alarm, 1'b1);
    check_eq("silence_state", io.state_dbg, 2'd0);

    // alarm 00:01 rings for two seconds
    press(K_L1);
    press(K_F2);
    press(K_L1);
    step_to(c2 + 59999);
    check_eq("alarm1_before", io.alarm_out, 1'b0);
    step_to(c2 + 60000);
    check_eq("alarm1_rise", io.alarm_out, 1'b1);
    step_to(c2 + 60001);
    check_eq("alarm1_disp", disp, 16'h0001);
    step_to(c2 + 60999);
    check_eq("alarm1_hold", io.alarm_out, 1'b1);
    step_to(c2 + 61000);
    check_eq("alarm1_fall", io.alarm_out, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/m_watch_alarm.md
# m_watch_alarm

24-hour digital watch with an alarm. It counts centiseconds, seconds, minutes and hours from a parametrised input clock, and drives four BCD digits to the 7-segment decoder plus status LEDs. It is the parametrised successor of the current watch. New behaviour over the current watch:
- edit copy, so time keeps running while the user edits it;
- separate alarm-setting mode;
- alarm with timed ring output and silence;
- digit-legal increment rules;
- synchronous reset.

It sits between the key debouncer/long-press detector and the HEX decoder.

## Interface
Parameters:
- IN_CLK_HZ, 50_000_000: input clock frequency. Must be a multiple of 100 and ≥ 100. TICK_DIV = IN_CLK_HZ/100.
- POINT_CS, 25: centisecond threshold for led_point (1..99).
- ALARM_SEC, 30: ring duration in seconds (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- key_first_1, key_first_2, key_long_1  in  1 each  single-cycle pulses from the debouncer.
- key_long_2  in  1  level, high while key 2 is held long.
- led_point  out  1  seconds blink.
- led_setting  out  1  high in SET_TIME or SET_ALARM.
- led_alarm  out  1  alarm enabled.
- alarm_out  out  1  alarm ringing.
- Hex_bit  out  2  digit selected for editing.
- Hex_0..Hex_3  out  4 each  BCD digits. Hex_0 is the least significant, Hex_3 the leftmost.

## Operation
- **Prescaler** counts 0..TICK_DIV-1. The tick pulse fires on the terminal count.
- **Time counters** are a BCD cascade: cs 00–99, ss 00–59, mm 00–59, hh 00–23. Each carry propagates on the same tick. 23:59:59.99 + tick gives 00:00:00.00.
- **Edit registers:** e_mm and e_hh (BCD).
- **Alarm registers:** a_mm and a_hh, reset to 00:00.
- **States:** TIME, SEC, SET_TIME, SET_ALARM. Reset state is TIME.
- **TIME**, priority highest first:
  - key_first_1 → SET_TIME. Load e_* from the current hh:mm; Hex_bit = 0.
  - key_long_1 → SET_ALARM. Load e_* from a_*; Hex_bit = 0.
  - key_long_2 = 1 → SEC.
  - key_first_2 toggles alarm_en.
- **SEC:** stay while key_long_2 = 1, otherwise → TIME. Key pulses are ignored.
- **SET_TIME / SET_ALARM:**
  - key_first_1: Hex_bit + 1, wrapping 3→0.
  - key_first_2: increment the selected edit digit (rules below).
  - key_long_1: commit and → TIME.
    - SET_TIME commit: hh:mm = e_*; ss, cs and the prescaler are cleared.
    - SET_ALARM commit: a_* = e_*.
  - Timekeeping keeps running during editing.
- **Digit increment rules:**
  - Digit 0 (minute units): 0–9, wraps to 0.
  - Digit 1 (minute tens): 0–5, wraps to 0.
  - Digit 2 (hour units): 0–9 when hour tens < 2; 0–3 when hour tens = 2.
  - Digit 3 (hour tens): 0–2, wraps to 0. If it becomes 2 while hour units > 3, hour units are forced to 0.
- **Display:**
  - TIME: mm units/tens on Hex_0/Hex_1, hh units/tens on Hex_2/Hex_3.
  - SEC: cs on Hex_0/Hex_1, ss on Hex_2/Hex_3.
  - SET_*: e_mm and e_hh in the same positions as TIME.
- **Alarm start:** on a tick that produces ss:cs = 00:00 with hh:mm == a_hh:a_mm while alarm_en = 1, alarm_out goes to 1 and the ring-seconds counter loads ALARM_SEC.
- **Alarm end:** the ring counter decrements at each second carry. alarm_out clears when the counter reaches 0.
- **Silence:** while alarm_out = 1, any key_first_1, key_first_2 or key_long_1 pulse clears alarm_out. That pulse is consumed and causes no state or edit change.
- **Disable:** setting alarm_en = 0 while ringing also clears alarm_out.
- led_point = (cs < POINT_CS).
- led_alarm = alarm_en.

## Timing
- All outputs are registered. Display and LED outputs reflect the counter/state values of the previous cycle (1-cycle latency).
- Reset (rst_n = 0 at a clk edge):
  - state TIME; all counters, e_*, a_*, alarm_en and ring counter = 0;
  - all outputs = 0, including led_point, Hex_bit and Hex_0..3;
  - reset overrides every other event, including mid-edit and mid-ring.
- A state transition takes effect on the clk edge that samples the pulse. The display shows the new mode one cycle later.
- SET_TIME commit on the same cycle as a tick: the commit wins and that tick is discarded.
- An alarm match on the same cycle as a silence pulse: the alarm does not start.
- A SET_ALARM commit that makes a_* equal to the current time does not ring until the next matching minute boundary.
- key_first_2 in TIME while ringing silences only; alarm_en is unchanged.

## Test plan
All scenarios use IN_CLK_HZ=500 (TICK_DIV=5), POINT_CS=25, ALARM_SEC=2.
1. **Reset:** hold rst_n = 0 for 3 cycles with keys toggling → every output 0 and state TIME. After release, a tick occurs every 5 cycles and led_point = 1 from the second cycle.
2. **Midnight rollover:** set 23:59 via SET_TIME and commit, then run 60 s (30 000 cycles) → Hex_3..Hex_0 go from 2,3,5,9 to 0,0,0,0 exactly on the carry tick.
3. **Edit rules:**
   - hour tens 1, units 7; increment digit 3 → tens 2, units 0.
   - with tens = 2, increment digit 2 four times → 1,2,3,0.
   - increment digit 1 six times from 0 → ends at 0.
   - time keeps advancing during the edit.
4. **SEC mode:** from 00:00:00.00, hold key_long_2 for 1 s → Hex_3..Hex_0 = 0,1,0,0. Release → TIME on the next cycle, showing 0,0,0,0.
5. **Alarm:** set the alarm to 00:01, enable it, start from 00:00 → alarm_out rises on the 00:01:00.00 tick and falls 2 s later. Repeat with a key_first_2 pulse after 0.5 s → alarm_out falls on the next cycle and alarm_en stays 1.
6. **Commit vs tick:** issue the key_long_1 commit on a tick cycle → cs = 00 and the prescaler restarts from 0.
